// File: rtl/time_value_entry.sv
// Two-digit keypad entry for hour/minute/second fields with per-keystroke range check and a load strobe.
// Optional: define TIME_ENTRY_CLEAR_EN to make key 4'hA clear the active field.
//
// state | meaning
// IDLE  | waiting for the setting FSM to select a field
// ENTRY | digits accumulate into the active field
// LOAD  | one-cycle load_time strobe
// DONE  | wait for completeSetting to drop
module time_value_entry #(
  parameter int HOUR_MAX   = 23,
  parameter int MINSEC_MAX = 59
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       hour_en,
  input  logic       min_en,
  input  logic       sec_en,
  input  logic       completeSetting,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       load_time,
  output logic       key_reject,
  output logic       entry_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ENTRY = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [6:0] HOUR_LIMIT   = 7'(HOUR_MAX);
  localparam logic [6:0] MINSEC_LIMIT = 7'(MINSEC_MAX);

  logic [1:0] state_q, state_d;
  logic       cs_q;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       reject_q, reject_d;

  logic       sel_hour, sel_min, sel_sec, field_active;
  logic [5:0] cur_val;
  logic [6:0] cur_max;
  logic [3:0] last_digit;
  logic [6:0] candidate;
  logic [6:0] new_val;
  logic       in_entry, digit_hit, accept, clear_hit, write_en, cs_rise;

  // Upstream may leave several enables high; the most recently reached field wins.
  assign sel_sec      = sec_en;
  assign sel_min      = min_en & ~sec_en;
  assign sel_hour     = hour_en & ~min_en & ~sec_en;
  assign field_active = sel_sec | sel_min | sel_hour;

  always_comb begin
    cur_val = 6'd0;
    cur_max = MINSEC_LIMIT;
    if (sel_sec) begin
      cur_val = sec_q;
    end else if (sel_min) begin
      cur_val = min_q;
    end else if (sel_hour) begin
      cur_val = {1'b0, hour_q};
      cur_max = HOUR_LIMIT;
    end
  end

  // Rolling entry: keep the previous units digit as tens, computed at 7 bits (max 99).
  assign last_digit = 4'(cur_val % 6'd10);
  assign candidate  = ({3'b000, last_digit} * 7'd10) + {3'b000, key_code};

  assign in_entry  = (state_q == ENTRY);
  assign digit_hit = in_entry & key_valid & field_active & (key_code <= 4'd9);
  assign accept    = digit_hit & (candidate <= cur_max);
  assign reject_d  = digit_hit & ~accept;

`ifdef TIME_ENTRY_CLEAR_EN
  assign clear_hit = in_entry & key_valid & field_active & (key_code == 4'hA);
`else
  assign clear_hit = 1'b0;
`endif

  assign write_en = accept | clear_hit;
  assign new_val  = clear_hit ? 7'd0 : candidate;

  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (write_en) begin
      if (sel_sec) begin
        sec_d = 6'(new_val);
      end else if (sel_min) begin
        min_d = 6'(new_val);
      end else if (sel_hour) begin
        hour_d = 5'(new_val);
      end
    end
  end

  assign cs_rise = completeSetting & ~cs_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hour_en | min_en | sec_en) begin
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (cs_rise) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = DONE;
      end
      DONE: begin
        if (!completeSetting) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      cs_q     <= 1'b0;
      hour_q   <= 5'd0;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_q     <= completeSetting;
      hour_q   <= hour_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      reject_q <= reject_d;
    end
  end

  assign set_hour   = hour_q;
  assign set_min    = min_q;
  assign set_sec    = sec_q;
  assign load_time  = (state_q == LOAD);
  assign key_reject = reject_q;
  assign entry_busy = in_entry;

endmodule

// File: tb/tb_time_value_entry.sv
// Scoreboard bench for time_value_entry: stimulus queues hand-computed expectations, a monitor checks them.
module tb_time_value_entry;

  logic       clock;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       hour_en, min_en, sec_en, completeSetting;
  logic [4:0] set_hour;
  logic [5:0] set_min, set_sec;
  logic       load_time, key_reject, entry_busy;

  time_value_entry #(.HOUR_MAX(23), .MINSEC_MAX(59)) dut (
    .clock           (clock),
    .reset           (reset),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .hour_en         (hour_en),
    .min_en          (min_en),
    .sec_en          (sec_en),
    .completeSetting (completeSetting),
    .set_hour        (set_hour),
    .set_min         (set_min),
    .set_sec         (set_sec),
    .load_time       (load_time),
    .key_reject      (key_reject),
    .entry_busy      (entry_busy)
  );

  typedef struct {
    int   due;
    int   h;
    int   m;
    int   s;
    logic rej;
    logic load;
    logic busy;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic stim_done = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic cmp(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Drive one cycle of key input and queue the state expected after the next edge.
  task automatic step(input logic kv, input logic [3:0] kc, input int h, input int m,
                      input int s, input logic rej, input logic load, input logic busy);
    exp_t e;
    key_valid = kv;
    key_code  = kc;
    e.due  = cyc + 1;
    e.h    = h;
    e.m    = m;
    e.s    = s;
    e.rej  = rej;
    e.load = load;
    e.busy = busy;
    q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    exp_t e;
    int   idle_cnt;
    logic matched;
    idle_cnt = 0;
    forever begin
      @(negedge clock);
      matched = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        matched = 1'b1;
        cmp("set_hour", int'(set_hour), e.h);
        cmp("set_min", int'(set_min), e.m);
        cmp("set_sec", int'(set_sec), e.s);
        cmp("key_reject", int'(key_reject), int'(e.rej));
        cmp("load_time", int'(load_time), int'(e.load));
        cmp("entry_busy", int'(entry_busy), int'(e.busy));
      end
      if (!matched && (key_reject || load_time)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got reject=%0b load=%0b expected none (cycle %0d)",
                 key_reject, load_time, cyc);
      end
      if (stim_done) begin
        idle_cnt++;
        if (q.size() == 0) begin
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end else if (idle_cnt > 20) begin
          checks++;
          errors++;
          $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end
      end
    end
  end

  initial begin
    int sa, sb;
`ifdef TIME_ENTRY_CLEAR_EN
    sa = 0;
    sb = 5;
`else
    sa = 42;
    sb = 25;
`endif
    reset = 1'b0;
    key_valid = 1'b0;
    key_code = 4'd0;
    hour_en = 1'b0;
    min_en = 1'b0;
    sec_en = 1'b0;
    completeSetting = 1'b0;

    step(1'b0, 4'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;

    // Hour entry with rolling two digits and range rejection
    hour_en = 1'b1;
    step(1'b0, 4'd0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd1, 1, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd2, 12, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 12, 0, 0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 4'd0, 12, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd3, 23, 0, 0, 1'b0, 1'b0, 1'b1);

    // Overlapping enables: minute beats hour, second beats both
    min_en = 1'b1;
    step(1'b1, 4'd4, 23, 4, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 23, 45, 0, 1'b0, 1'b0, 1'b1);
    sec_en = 1'b1;
    step(1'b1, 4'd4, 23, 45, 4, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd2, 23, 45, 42, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'hB, 23, 45, 42, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'hA, 23, 45, sa, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd5, 23, 45, sb, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd9, 23, 45, 59, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd9, 23, 45, 59, 1'b1, 1'b0, 1'b1);

    // Digit and completeSetting rise together: digit lands, then LOAD
    sec_en = 1'b0;
    completeSetting = 1'b1;
    step(1'b1, 4'd3, 23, 53, 59, 1'b0, 1'b1, 1'b0);
    step(1'b1, 4'd1, 23, 53, 59, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd2, 23, 53, 59, 1'b0, 1'b0, 1'b0);
    completeSetting = 1'b0;
    step(1'b0, 4'd0, 23, 53, 59, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 23, 53, 59, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd3, 23, 33, 59, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd0, 23, 30, 59, 1'b0, 1'b0, 1'b1);

    // Reset mid-entry clears everything
    reset = 1'b0;
    step(1'b1, 4'd7, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    hour_en = 1'b0;
    min_en = 1'b0;
    step(1'b1, 4'd7, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    key_valid = 1'b0;
    stim_done = 1'b1;
  end

endmodule

// File: doc/time_value_entry.md
Name: time_value_entry

Overview:
- Downstream consumer of the manual time-setting FSM.
- Takes that FSM's field enables (hour_en / min_en / sec_en) and its completeSetting flag, plus decoded keypad digit events.
- Accumulates a two-digit decimal value per field and range-checks every keystroke.
- On completion, presents binary hour/minute/second values with a one-cycle load strobe for the timekeeping counter.

Parameters:
- HOUR_MAX, 23, largest accepted hour value.
- MINSEC_MAX, 59, largest accepted minute/second value.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (sampled on rising clock edge; 0 = reset).
- key_valid  input  1  one-cycle pulse; key_code is valid this cycle.
- key_code  input  4  decoded key: 0-9 digits; 4'hA star; others ignored.
- hour_en  input  1  hour field selected by the setting FSM.
- min_en  input  1  minute field selected.
- sec_en  input  1  second field selected.
- completeSetting  input  1  setting finished (level, may stay high).
- set_hour  output  5  entered hour, binary 0..HOUR_MAX.
- set_min  output  6  entered minute, binary 0..MINSEC_MAX.
- set_sec  output  6  entered second, binary 0..MINSEC_MAX.
- load_time  output  1  one-cycle strobe; set_* are valid to load.
- key_reject  output  1  one-cycle pulse; digit refused (out of range).
- entry_busy  output  1  high while in ENTRY state.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE.
  - set_hour, set_min, set_sec = 0.
  - load_time, key_reject, entry_busy = 0.
  - completeSetting edge register = 0.
- Active field selection:
  - Input enables may overlap, because upstream does not clear every enable.
  - Priority is sec_en > min_en > hour_en.
  - No enable high: no active field.
- States:
  - IDLE: any enable high -> ENTRY next cycle. Digits ignored.
  - ENTRY:
    - entry_busy=1.
    - Digit processing per the Digit entry rules below.
    - Rising edge of completeSetting (registered previous value 0, current 1) -> LOAD.
  - LOAD: load_time=1 for exactly this cycle; -> DONE. Digits ignored.
  - DONE:
    - Digits ignored.
    - completeSetting==0 -> IDLE.
    - Otherwise stay.
  - Illegal encoding -> IDLE.
- Digit entry (ENTRY only; key_valid=1, key_code<=9, active field exists):
  - Candidate = (current field value mod 10)*10 + key_code, i.e. a rolling last-two-digits entry.
  - Candidate <= field max: field <= candidate.
  - Otherwise: field unchanged; key_reject=1 for one cycle.
  - Examples:
    - Hour 0, keys 1,2 -> 12.
    - Then key 5: candidate 25 > 23 -> rejected, stays 12.
    - Then key 3 -> 23.
- Ignored keys: key_code 4'hB..4'hF, and 4'hA when the option is disabled. No effect; no reject pulse.
- Simultaneous events: a completeSetting rising edge and key_valid in the same ENTRY cycle.
  - The digit is applied first.
  - LOAD follows next cycle with the updated value.
- Latency:
  - Field register updates 1 cycle after the key_valid cycle.
  - load_time asserts 1 cycle after the completeSetting rise is sampled.
- set_* hold their values through IDLE/DONE. They are cleared only by reset.
- Reset mid-entry: all fields return to 0, state IDLE; any pending load is discarded.
- Width rules:
  - Internal multiply-by-10 computed at 7 bits (max 99) before the compare.
  - Result truncated to the field width only after acceptance.

Optional Feature:
- Macro: TIME_ENTRY_CLEAR_EN.
- Defined: key_code 4'hA with key_valid in ENTRY clears the active field to 0 the next cycle; no reject pulse.
- Undefined: 4'hA is an ignored key.

Test Plan:
- Reset, then hour_en=1, key_valid digits 1,2 -> set_hour=12 two cycles later, key_reject never pulses, entry_busy=1.
- Hour field at 12, digit 5 -> key_reject one-cycle pulse, set_hour stays 12; digit 3 -> set_hour=23.
- hour_en=1 and min_en=1, digits 4,5 -> set_min=45, set_hour unchanged; add sec_en=1, digits 5,9 -> set_sec=59; digit 9 -> reject, stays 59.
- completeSetting 0->1 while in ENTRY -> load_time high exactly 1 cycle, then DONE; digits ignored while completeSetting held high; completeSetting=0 -> IDLE.
- reset=0 during ENTRY with set_min=30 -> next edge: all set_*=0, state IDLE, load_time=0.
- With TIME_ENTRY_CLEAR_EN: set_sec=42, key 4'hA -> set_sec=0, no reject. Without the macro: set_sec stays 42.
